pkt_dma_wr: RTL and testbench

- Packet-to-memory DMA write engine. It feeds the DMA write port of the multi-core memory subsystem.
- Accepts a 256-bit packet beat stream from the packet-processing stage and writes each packet into a ring of fixed-size slots in shared packet memory.
- After the last data beat it writes a one-word-pair descriptor at the slot head.
- Software (NanoCore) returns slots via a free pulse; the block drops packets when no slot is free.

---
 rtl/pkt_dma_wr_if.sv | 33 +++
 rtl/pkt_dma_wr.sv | 210 +++++++++++++++++++++
 tb/tb_pkt_dma_wr.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_dma_wr_if.sv
// Bus bundle for pkt_dma_wr: the 256-bit packet beat stream in and the DMA
// write port out.
//   pkt_valid/sop/eop/nwords/data : beat stream from the packet stage
//   pkt_ready                     : engine accepts the beat this cycle
//   dma_rden/wren/addr/wdata/wstrb/winc : DMA request to packet memory
//   dma_gnt                       : memory accepts the write this cycle
// Modport master is the DMA engine; slave is the packet source plus memory.
interface pkt_dma_wr_if;
    logic         pkt_valid;
    logic         pkt_sop;
    logic         pkt_eop;
    logic [3:0]   pkt_nwords;
    logic [255:0] pkt_data;
    logic         pkt_ready;

    logic         dma_rden;
    logic         dma_wren;
    logic [31:0]  dma_addr;
    logic [255:0] dma_wdata;
    logic [7:0]   dma_wstrb;
    logic [7:0]   dma_winc;
    logic         dma_gnt;

    modport master (
        input  pkt_valid, pkt_sop, pkt_eop, pkt_nwords, pkt_data, dma_gnt,
        output pkt_ready, dma_rden, dma_wren, dma_addr, dma_wdata, dma_wstrb, dma_winc
    );

    modport slave (
        output pkt_valid, pkt_sop, pkt_eop, pkt_nwords, pkt_data, dma_gnt,
        input  pkt_ready, dma_rden, dma_wren, dma_addr, dma_wdata, dma_wstrb, dma_winc
    );
endinterface

// File: rtl/pkt_dma_wr.sv
// Packet-to-memory DMA write engine. Each packet is written into the next
// slot of a ring in packet memory (data from slot byte 32 on), then a
// descriptor {truncated, length} / seq is written at the slot head.
// Packets arriving with no free slot are dropped and counted.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_buf_base     : ring base byte address (32-byte aligned, static)
//   i_slot_free    : one-cycle pulse, software returned one slot
//   bus_io         : beat stream in, DMA write port out
//   o_free_cnt     : free slots
//   o_pkt_cnt      : packets written (wraps)
//   o_drop_cnt     : packets dropped (wraps)
module pkt_dma_wr #(
    parameter int unsigned NUM_SLOTS  = 16,
    parameter int unsigned SLOT_BYTES = 2048
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_buf_base,
    input  logic         i_slot_free,
    pkt_dma_wr_if.master bus_io,
    output logic [8:0]   o_free_cnt,
    output logic [31:0]  o_pkt_cnt,
    output logic [31:0]  o_drop_cnt
);

    localparam int unsigned PtrW      = $clog2(NUM_SLOTS);
    localparam int unsigned SlotShift = $clog2(SLOT_BYTES);
    // Data beats that fit after the 32-byte descriptor.
    localparam int unsigned MaxBeats  = SLOT_BYTES / 32 - 1;
    localparam logic [15:0] TruncLen  = 16'(32 * MaxBeats);

    typedef enum logic [1:0] {StIdle, StData, StDrop, StDesc} state_e;

    state_e           state_q, state_d;
    logic             wren_q, wren_d;
    logic [31:0]      addr_q, addr_d;
    logic [255:0]     wdata_q, wdata_d;
    logic [7:0]       wstrb_q, wstrb_d;
    logic [31:0]      slot_base_q, slot_base_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    logic             trunc_q, trunc_d;
    logic [15:0]      len_q, len_d;
    logic             desc_sent_q, desc_sent_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [8:0]       free_cnt_q, free_cnt_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;
    logic [31:0]      drop_cnt_q, drop_cnt_d;
    logic [31:0]      seq_q, seq_d;

    logic             pkt_ready;
    logic             accept;
    logic             alloc;
    logic [8:0]       eop_mask;
    logic [7:0]       beat_strb;
    logic [15:0]      desc_len;

    assign accept    = bus_io.pkt_valid & pkt_ready;
    assign eop_mask  = (9'd1 << bus_io.pkt_nwords) - 9'd1;
    assign beat_strb = bus_io.pkt_eop ? eop_mask[7:0] : 8'hFF;
    assign desc_len  = trunc_q ? TruncLen : len_q;

    always_comb begin
        state_d     = state_q;
        // A granted write retires unless a new one is loaded below.
        wren_d      = wren_q & ~bus_io.dma_gnt;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        slot_base_d = slot_base_q;
        beat_cnt_d  = beat_cnt_q;
        trunc_d     = trunc_q;
        len_d       = len_q;
        desc_sent_d = desc_sent_q;
        wr_ptr_d    = wr_ptr_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        seq_d       = seq_q;
        alloc       = 1'b0;
        pkt_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                pkt_ready = ~wren_q | bus_io.dma_gnt;
                if (accept && bus_io.pkt_sop) begin
                    if (free_cnt_q == 9'd0) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        if (!bus_io.pkt_eop) state_d = StDrop;
                    end else begin
                        alloc       = 1'b1;
                        slot_base_d = i_buf_base + (32'(wr_ptr_q) << SlotShift);
                        wren_d      = 1'b1;
                        addr_d      = slot_base_d + 32'd32;
                        wdata_d     = bus_io.pkt_data;
                        wstrb_d     = beat_strb;
                        beat_cnt_d  = 16'd1;
                        trunc_d     = 1'b0;
                        if (bus_io.pkt_eop) begin
                            len_d       = 16'({bus_io.pkt_nwords, 2'b00});
                            desc_sent_d = 1'b0;
                            state_d     = StDesc;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                pkt_ready = ~wren_q | bus_io.dma_gnt;
                if (accept) begin
                    if (beat_cnt_q < 16'(MaxBeats)) begin
                        wren_d     = 1'b1;
                        addr_d     = addr_q + 32'd32;
                        wdata_d    = bus_io.pkt_data;
                        wstrb_d    = beat_strb;
                        beat_cnt_d = beat_cnt_q + 16'd1;
                        len_d      = 16'({beat_cnt_q, 5'b0}) + 16'({bus_io.pkt_nwords, 2'b00});
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (bus_io.pkt_eop) begin
                        desc_sent_d = 1'b0;
                        state_d     = StDesc;
                    end
                end
            end
            StDrop: begin
                pkt_ready = 1'b1;
                if (bus_io.pkt_valid && bus_io.pkt_eop) state_d = StIdle;
            end
            StDesc: begin
                if (!desc_sent_q) begin
                    // Descriptor goes out only once the last data write is granted.
                    if (!wren_q || bus_io.dma_gnt) begin
                        wren_d      = 1'b1;
                        addr_d      = slot_base_q;
                        wdata_d     = {192'd0, seq_q, trunc_q, 15'd0, desc_len};
                        wstrb_d     = 8'h03;
                        desc_sent_d = 1'b1;
                    end
                end else if (bus_io.dma_gnt) begin
                    seq_d     = seq_q + 32'd1;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    wr_ptr_d  = (wr_ptr_q == PtrW'(NUM_SLOTS - 1)) ? '0 : wr_ptr_q + 1'b1;
                    trunc_d   = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Allocation and a free pulse in the same cycle cancel out.
    always_comb begin
        free_cnt_d = free_cnt_q;
        if (alloc && !i_slot_free) begin
            free_cnt_d = free_cnt_q - 9'd1;
        end else if (!alloc && i_slot_free && free_cnt_q != 9'(NUM_SLOTS)) begin
            free_cnt_d = free_cnt_q + 9'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            slot_base_q <= '0;
            beat_cnt_q  <= '0;
            trunc_q     <= 1'b0;
            len_q       <= '0;
            desc_sent_q <= 1'b0;
            wr_ptr_q    <= '0;
            free_cnt_q  <= 9'(NUM_SLOTS);
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            seq_q       <= '0;
        end else begin
            state_q     <= state_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            slot_base_q <= slot_base_d;
            beat_cnt_q  <= beat_cnt_d;
            trunc_q     <= trunc_d;
            len_q       <= len_d;
            desc_sent_q <= desc_sent_d;
            wr_ptr_q    <= wr_ptr_d;
            free_cnt_q  <= free_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            seq_q       <= seq_d;
        end
    end

    assign bus_io.pkt_ready = pkt_ready;
    assign bus_io.dma_rden  = 1'b0;
    assign bus_io.dma_wren  = wren_q;
    assign bus_io.dma_addr  = addr_q;
    assign bus_io.dma_wdata = wdata_q;
    assign bus_io.dma_wstrb = wstrb_q;
    assign bus_io.dma_winc  = 8'h00;

    assign o_free_cnt = free_cnt_q;
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pkt_dma_wr.sv
// Directed bench for pkt_dma_wr (NUM_SLOTS=16, SLOT_BYTES=2048).
module tb_pkt_dma_wr;

    logic        clk;
    logic        rst_n;
    logic [31:0] buf_base;
    logic        slot_free;
    logic [8:0]  free_cnt;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    int total;
    int bad;

    logic [31:0]  log_addr[$];
    logic [7:0]   log_strb[$];
    logic [255:0] log_data[$];

    pkt_dma_wr_if bus ();

    pkt_dma_wr #(
        .NUM_SLOTS  (16),
        .SLOT_BYTES (2048)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_buf_base  (buf_base),
        .i_slot_free (slot_free),
        .bus_io      (bus),
        .o_free_cnt  (free_cnt),
        .o_pkt_cnt   (pkt_cnt),
        .o_drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every granted DMA write.
    always @(posedge clk) begin
        if (rst_n && bus.dma_wren && bus.dma_gnt) begin
            log_addr.push_back(bus.dma_addr);
            log_strb.push_back(bus.dma_wstrb);
            log_data.push_back(bus.dma_wdata);
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_strb.delete();
        log_data.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        slot_free      = 1'b0;
        bus.pkt_valid  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_beat(input logic sop, input logic eop, input logic [3:0] nw,
                             input logic [255:0] data);
        int   n;
        logic acc;
        bus.pkt_valid  = 1'b1;
        bus.pkt_sop    = sop;
        bus.pkt_eop    = eop;
        bus.pkt_nwords = nw;
        bus.pkt_data   = data;
        n = 0;
        do begin
            #1;
            acc = bus.pkt_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL beat_accept: ready=%0b after %0d cycles, required 1", acc, n);
        end
        bus.pkt_valid = 1'b0;
        bus.pkt_sop   = 1'b0;
        bus.pkt_eop   = 1'b0;
    endtask

    task automatic send_pkt(input int nbeats, input logic [3:0] nw, input logic [31:0] tag);
        for (int b = 0; b < nbeats; b++) begin
            send_beat(b == 0, b == nbeats - 1, nw, {8{tag + 32'(b)}});
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.dma_wren !== 1'b0 || bus.dma_addr !== 32'd0 || bus.dma_wstrb !== 8'd0 ||
            bus.dma_wdata !== 256'd0) begin
            bad++;
            $display("FAIL reset_dma: wren=%0b addr=%h strb=%h, required 0/0/0",
                     bus.dma_wren, bus.dma_addr, bus.dma_wstrb);
        end
        total++;
        if (free_cnt !== 9'd16 || pkt_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_counts: free=%0d pkt=%0d drop=%0d, required 16/0/0",
                     free_cnt, pkt_cnt, drop_cnt);
        end
        total++;
        if (bus.dma_rden !== 1'b0 || bus.dma_winc !== 8'd0 || bus.pkt_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_misc: rden=%0b winc=%h ready=%0b, required 0/00/1",
                     bus.dma_rden, bus.dma_winc, bus.pkt_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_log();
        send_pkt(3, 4'd5, 32'hA0);
        total++;
        if (log_addr.size() != 4) begin
            bad++;
            $display("FAIL basic_nwrites: got %0d, required 4", log_addr.size());
        end else begin
            total++;
            if (log_addr[0] !== 32'h10020 || log_addr[1] !== 32'h10040 ||
                log_addr[2] !== 32'h10060 || log_addr[3] !== 32'h10000) begin
                bad++;
                $display("FAIL basic_addr: got %h %h %h %h, required 10020 10040 10060 10000",
                         log_addr[0], log_addr[1], log_addr[2], log_addr[3]);
            end
            total++;
            if (log_strb[0] !== 8'hFF || log_strb[1] !== 8'hFF || log_strb[2] !== 8'h1F ||
                log_strb[3] !== 8'h03) begin
                bad++;
                $display("FAIL basic_strb: got %h %h %h %h, required ff ff 1f 03",
                         log_strb[0], log_strb[1], log_strb[2], log_strb[3]);
            end
            total++;
            if (log_data[0] !== {8{32'hA0}} || log_data[2] !== {8{32'hA2}}) begin
                bad++;
                $display("FAIL basic_data: got %h / %h, required a0.. / a2..",
                         log_data[0][31:0], log_data[2][31:0]);
            end
            total++;
            if (log_data[3] !== {192'd0, 32'd0, 32'h0000_0054}) begin
                bad++;
                $display("FAIL basic_desc: got w0=%h w1=%h, required 00000054/0",
                         log_data[3][31:0], log_data[3][63:32]);
            end
        end
        total++;
        if (pkt_cnt !== 32'd1 || free_cnt !== 9'd15) begin
            bad++;
            $display("FAIL basic_counts: pkt=%0d free=%0d, required 1/15", pkt_cnt, free_cnt);
        end
    endtask

    task automatic test_stall();
        clear_log();
        @(negedge clk);
        bus.dma_gnt = 1'b0;
        send_beat(1'b1, 1'b1, 4'd8, {8{32'hB0}});
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.dma_wren !== 1'b1 || bus.dma_addr !== 32'h10820 ||
                bus.dma_wdata !== {8{32'hB0}} || bus.dma_wstrb !== 8'hFF ||
                bus.pkt_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: wren=%0b addr=%h strb=%h ready=%0b, required 1/10820/ff/0",
                         i, bus.dma_wren, bus.dma_addr, bus.dma_wstrb, bus.pkt_ready);
            end
            @(negedge clk);
        end
        bus.dma_gnt = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (log_addr.size() != 2) begin
            bad++;
            $display("FAIL stall_nwrites: got %0d, required 2", log_addr.size());
        end else begin
            total++;
            if (log_addr[1] !== 32'h10800 || log_data[1][63:0] !== {32'd1, 32'h20}) begin
                bad++;
                $display("FAIL stall_desc: addr=%h w0=%h w1=%h, required 10800/20/1",
                         log_addr[1], log_data[1][31:0], log_data[1][63:32]);
            end
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int p = 0; p < 16; p++) send_pkt(1, 4'd1, 32'(p));
        total++;
        if (free_cnt !== 9'd0 || pkt_cnt !== 32'd16) begin
            bad++;
            $display("FAIL full_counts: free=%0d pkt=%0d, required 0/16", free_cnt, pkt_cnt);
        end
        clear_log();
        send_pkt(2, 4'd8, 32'hC0);
        total++;
        if (log_addr.size() != 0 || drop_cnt !== 32'd1 || free_cnt !== 9'd0) begin
            bad++;
            $display("FAIL drop: writes=%0d drop=%0d free=%0d, required 0/1/0",
                     log_addr.size(), drop_cnt, free_cnt);
        end
        slot_free = 1'b1;
        @(negedge clk);
        slot_free = 1'b0;
        total++;
        if (free_cnt !== 9'd1) begin
            bad++;
            $display("FAIL free_pulse: free=%0d, required 1", free_cnt);
        end
        send_pkt(1, 4'd2, 32'hD0);
        total++;
        if (log_addr.size() != 2) begin
            bad++;
            $display("FAIL wrap_nwrites: got %0d, required 2", log_addr.size());
        end else begin
            total++;
            if (log_addr[0] !== 32'h10020 || log_addr[1] !== 32'h10000 ||
                log_data[1][63:0] !== {32'd16, 32'h8}) begin
                bad++;
                $display("FAIL wrap_slot0: addr=%h desc=%h w0=%h w1=%0d, required 10020/10000/8/16",
                         log_addr[0], log_addr[1], log_data[1][31:0], log_data[1][63:32]);
            end
        end
    endtask

    task automatic test_truncate();
        do_reset();
        clear_log();
        send_pkt(70, 4'd3, 32'hE00);
        total++;
        if (log_addr.size() != 64) begin
            bad++;
            $display("FAIL trunc_nwrites: got %0d, required 64", log_addr.size());
        end else begin
            total++;
            if (log_addr[62] !== 32'h107E0 || log_strb[62] !== 8'hFF) begin
                bad++;
                $display("FAIL trunc_last: addr=%h strb=%h, required 107e0/ff",
                         log_addr[62], log_strb[62]);
            end
            total++;
            if (log_addr[63] !== 32'h10000 || log_data[63][63:0] !== {32'd0, 32'h8000_07E0}) begin
                bad++;
                $display("FAIL trunc_desc: addr=%h w0=%h w1=%h, required 10000/800007e0/0",
                         log_addr[63], log_data[63][31:0], log_data[63][63:32]);
            end
        end
        total++;
        if (pkt_cnt !== 32'd1) begin
            bad++;
            $display("FAIL trunc_pkt_cnt: got %0d, required 1", pkt_cnt);
        end
    endtask

    task automatic test_free_coincide();
        do_reset();
        for (int p = 0; p < 11; p++) send_pkt(1, 4'd1, 32'(p));
        total++;
        if (free_cnt !== 9'd5) begin
            bad++;
            $display("FAIL coin_pre: free=%0d, required 5", free_cnt);
        end
        bus.pkt_valid  = 1'b1;
        bus.pkt_sop    = 1'b1;
        bus.pkt_eop    = 1'b1;
        bus.pkt_nwords = 4'd1;
        bus.pkt_data   = {8{32'hF0}};
        slot_free      = 1'b1;
        #1;
        total++;
        if (bus.pkt_ready !== 1'b1) begin
            bad++;
            $display("FAIL coin_ready: ready=%0b, required 1", bus.pkt_ready);
        end
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        bus.pkt_sop   = 1'b0;
        bus.pkt_eop   = 1'b0;
        slot_free     = 1'b0;
        total++;
        if (free_cnt !== 9'd5) begin
            bad++;
            $display("FAIL coin_free: free=%0d, required 5", free_cnt);
        end
        repeat (6) @(negedge clk);
        total++;
        if (pkt_cnt !== 32'd12) begin
            bad++;
            $display("FAIL coin_pkt: pkt=%0d, required 12", pkt_cnt);
        end
        slot_free = 1'b1;
        @(negedge clk);
        slot_free = 1'b0;
        total++;
        if (free_cnt !== 9'd6) begin
            bad++;
            $display("FAIL free_inc: free=%0d, required 6", free_cnt);
        end
        do_reset();
        slot_free = 1'b1;
        @(negedge clk);
        slot_free = 1'b0;
        total++;
        if (free_cnt !== 9'd16) begin
            bad++;
            $display("FAIL free_sat: free=%0d, required 16", free_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_pkt(1, 4'd4, 32'h11);
        send_beat(1'b1, 1'b0, 4'd8, {8{32'h20}});
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = {8{32'h21}};
        rst_n         = 1'b0;
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        total++;
        if (bus.dma_wren !== 1'b0 || pkt_cnt !== 32'd0 || drop_cnt !== 32'd0 ||
            free_cnt !== 9'd16) begin
            bad++;
            $display("FAIL midrst: wren=%0b pkt=%0d drop=%0d free=%0d, required 0/0/0/16",
                     bus.dma_wren, pkt_cnt, drop_cnt, free_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send_pkt(1, 4'd2, 32'h30);
        total++;
        if (log_addr.size() != 2) begin
            bad++;
            $display("FAIL midrst_nwrites: got %0d, required 2", log_addr.size());
        end else begin
            total++;
            if (log_addr[0] !== 32'h10020 || log_addr[1] !== 32'h10000 ||
                log_data[1][63:0] !== {32'd0, 32'h8}) begin
                bad++;
                $display("FAIL midrst_slot: addr=%h desc=%h w0=%h w1=%0d, required 10020/10000/8/0",
                         log_addr[0], log_addr[1], log_data[1][31:0], log_data[1][63:32]);
            end
        end
        total++;
        if (pkt_cnt !== 32'd1) begin
            bad++;
            $display("FAIL midrst_pkt: pkt=%0d, required 1", pkt_cnt);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        buf_base       = 32'h0001_0000;
        slot_free      = 1'b0;
        bus.pkt_valid  = 1'b0;
        bus.pkt_sop    = 1'b0;
        bus.pkt_eop    = 1'b0;
        bus.pkt_nwords = 4'd0;
        bus.pkt_data   = '0;
        bus.dma_gnt    = 1'b1;

        test_reset();
        test_basic();
        test_stall();
        test_full_drop();
        test_truncate();
        test_free_coincide();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
